// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// the signed-minimum helper used for overflow cases.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_LUI  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01111;
  localparam logic [4:0] OP_MULU = 5'b10000;
  localparam logic [4:0] OP_MUL  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10010;
  localparam logic [4:0] OP_DIV  = 5'b10011;

  localparam int unsigned MAX_WIDTH = 128;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    m[width-1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied on the outputs.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0]   acc, mq, opnd;
  logic [SHW:0]       cnt;
  logic               div_mode, neg_lo, neg_hi;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, trial;
  logic               fits;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = is_signed && a[WIDTH-1];
  assign b_neg = is_signed && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign sum     = {1'b0, acc} + {1'b0, (mq[0] ? opnd : {WIDTH{1'b0}})};
  assign shifted = {acc, mq[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd};
  assign fits    = shifted >= {1'b0, opnd};

  assign last     = cnt == (SHW+1)'(1);
  assign prod     = {acc, mq};
  assign prod_fix = neg_lo ? -prod : prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      mq       <= mag_a;
      opnd     <= mag_b;
      cnt      <= (SHW+1)'(WIDTH);
      div_mode <= is_div;
      neg_lo   <= a_neg ^ b_neg;
      neg_hi   <= is_div && a_neg;
    end else if (step) begin
      // Divide shifts the dividend into acc one bit per step; a shifted value
      // with its top bit set always exceeds the divisor, so it never truncates.
      if (div_mode) begin
        acc <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], fits};
      end else begin
        acc <= sum[WIDTH:1];
        mq  <= {sum[0], mq[WIDTH-1:1]};
      end
      cnt <= cnt - (SHW+1)'(1);
    end
  end

  always_comb begin
    if (div_mode) begin
      lo = neg_lo ? -mq : mq;
      hi = neg_hi ? -acc : acc;
    end else begin
      lo = prod_fix[WIDTH-1:0];
      hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle ops and iterative mul/div behind a
// start/busy/done handshake.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic             pend_valid;
  logic [4:0]       pend_op;
  logic [WIDTH-1:0] pend_a, pend_b;
  logic             is_muldiv, is_div, div_zero, pend_multi, accept;
  logic             load, step, last, upd;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] quick, res_s, res_hi, iter_lo, iter_hi;

  assign is_muldiv  = pend_op[4] && (pend_op[3:2] == 2'b00);
  assign is_div     = pend_op[1];
  assign div_zero   = is_div && (pend_b == '0);
  assign pend_multi = pend_valid && is_muldiv && !div_zero;
  assign busy       = state != IDLE;
  // The decode cycle of a mul/div is not yet busy but must not take a new request.
  assign accept     = start && !busy && !pend_multi;
  assign sh         = pend_a[SHW-1:0];

  always_comb begin
    quick = '0;
    if (!pend_op[4]) begin
      case (pend_op[2:0])
        3'b000: quick = pend_a + pend_b;
        3'b100: quick = pend_a - pend_b;
        3'b001: quick = pend_a & pend_b;
        3'b101: quick = pend_a | pend_b;
        3'b010: quick = pend_a ^ pend_b;
        3'b110: quick = pend_b << (WIDTH/2);
        3'b011: if (!pend_op[3]) quick = pend_b << sh;
        3'b111: begin
          if (pend_op[3]) quick = $signed(pend_b) >>> sh;
          else            quick = pend_b >> sh;
        end
        default: quick = '0;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    upd     = 1'b0;
    res_s   = '0;
    res_hi  = '0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          if (is_muldiv && !div_zero) begin
            load    = 1'b1;
            state_n = is_div ? DIV : MUL;
          end else begin
            upd = 1'b1;
            if (is_muldiv) begin
              res_s  = '1;
              res_hi = pend_a;
            end else begin
              res_s = quick;
            end
          end
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last) state_n = FIX;
      end
      FIX: begin
        upd     = 1'b1;
        res_s   = iter_lo;
        res_hi  = iter_hi;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_op    <= '0;
      pend_a     <= '0;
      pend_b     <= '0;
      s          <= '0;
      hi         <= '0;
      z          <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pend_valid <= accept;
      done       <= upd;
      if (accept) begin
        pend_op <= aluc;
        pend_a  <= a;
        pend_b  <= b;
      end
      if (upd) begin
        s  <= res_s;
        hi <= res_hi;
        z  <= res_s == '0;
      end
    end
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .is_div    (is_div),
    .is_signed (pend_op[0]),
    .a         (pend_a),
    .b         (pend_b),
    .last      (last),
    .lo        (iter_lo),
    .hi        (iter_hi)
  );

endmodule
